console_uart_tx: RTL and testbench

//  Downstream consumer of the md5calculator console port (o_console_data / o_console_send_hsreq).

---
 rtl/console_pkg.sv | 14 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/console_uart_tx.sv | 131 +++++++++++++
 tb/tb_console_uart_tx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Console UART transmitter shared types.
// Line state encoding and frame constants.
package console_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Pushes while full are dropped; pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW])
                 && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/console_uart_tx.sv
// Buffered 8N1 UART transmitter for the firmware console port.
// Overflow is sticky and flagged; the producer is never stalled.
module console_uart_tx
   import console_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic                          i_clear_ovf,
   output logic                          o_txd,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_overflow
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [2:0]  BIT_LAST = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t state, state_n;
   logic [15:0]    cnt, cnt_n;
   logic [2:0]     bit_idx, bit_n;
   logic [7:0]     shift, shift_n;
   logic [7:0]     head;
   logic           txd_n;
   logic           pop;
   logic           full;
   logic           empty;
   logic           baud_end;

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (i_valid),
      .wdata  (i_data),
      .pop    (pop),
      .rdata  (head),
      .full   (full),
      .empty  (empty),
      .level  (o_level)
   );

   assign o_ready  = ~full;
   assign o_busy   = (state != IDLE) | ~empty;
   assign baud_end = (cnt == DIV_LAST);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      txd_n   = 1'b1;
      if (state != IDLE) cnt_n = baud_end ? '0 : cnt + 16'd1;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               cnt_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud_end) begin
               state_n = DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            if (baud_end) begin
               shift_n = shift >> 1;
               if (bit_idx == BIT_LAST) state_n = STOP;
               else bit_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            // Chain straight into the next start bit to avoid an idle gap.
            if (baud_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = head;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      unique case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shift_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         o_txd   <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         o_txd   <= txd_n;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         o_overflow <= 1'b0;
      end else if (i_valid & full) begin
         o_overflow <= 1'b1;
      end else if (i_clear_ovf) begin
         o_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: fixed frame vectors, corner sequences,
// and a randomized run checked against a queue-based line model.
module tb_console_uart_tx;

   localparam int DIV1 = 4;
   localparam int DEP1 = 4;
   localparam int DIV2 = 2;
   localparam int DEP2 = 2;

   logic       clock;
   logic       resetn;
   logic [7:0] data1, data2;
   logic       valid1, valid2;
   logic       clr1, clr2;
   logic       ready1, ready2;
   logic       txd1, txd2;
   logic       busy1, busy2;
   logic       ovf1, ovf2;
   logic [2:0] level1;
   logic [1:0] level2;

   int n_pass = 0;
   int n_total = 0;
   int mon_ferr = 0;
   byte unsigned rxq0[$];
   byte unsigned rxq1[$];

   console_uart_tx #(.CLK_DIV(DIV1), .FIFO_DEPTH(DEP1)) dut1 (
      .clock       (clock),
      .resetn      (resetn),
      .i_data      (data1),
      .i_valid     (valid1),
      .o_ready     (ready1),
      .i_clear_ovf (clr1),
      .o_txd       (txd1),
      .o_busy      (busy1),
      .o_level     (level1),
      .o_overflow  (ovf1)
   );

   console_uart_tx #(.CLK_DIV(DIV2), .FIFO_DEPTH(DEP2)) dut2 (
      .clock       (clock),
      .resetn      (resetn),
      .i_data      (data2),
      .i_valid     (valid2),
      .o_ready     (ready2),
      .i_clear_ovf (clr2),
      .o_txd       (txd2),
      .o_busy      (busy2),
      .o_level     (level2),
      .o_overflow  (ovf2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [9:0] frame_of(input logic [7:0] d);
      logic [9:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9] = 1'b1;
      return f;
   endfunction

   // Mid-bit sampling UART receiver for both line outputs.
   initial begin : monitor
      int          cyc [2];
      bit          act [2];
      logic [7:0]  sr [2];
      int          div;
      int          idx;
      logic        line;
      act[0] = 0;
      act[1] = 0;
      forever begin
         @(negedge clock);
         for (int ch = 0; ch < 2; ch++) begin
            div  = (ch == 0) ? DIV1 : DIV2;
            line = (ch == 0) ? txd1 : txd2;
            if (!resetn) begin
               act[ch] = 0;
            end else if (!act[ch]) begin
               if (!line) begin
                  act[ch] = 1;
                  cyc[ch] = 0;
               end
            end else begin
               cyc[ch]++;
            end
            if (resetn && act[ch] && (cyc[ch] % div) == div / 2) begin
               idx = cyc[ch] / div;
               if (idx == 0) begin
                  if (line) mon_ferr++;
               end else if (idx <= 8) begin
                  sr[ch][idx-1] = line;
               end else begin
                  if (!line) mon_ferr++;
                  else if (ch == 0) rxq0.push_back(sr[ch]);
                  else rxq1.push_back(sr[ch]);
                  act[ch] = 0;
               end
            end
         end
      end
   end

   task automatic push1(input logic [7:0] d);
      data1  = d;
      valid1 = 1'b1;
      @(posedge clock); #1;
      valid1 = 1'b0;
   endtask

   task automatic sample_line(input int nbits, output logic [99:0] bits,
                              output int gl);
      bits = '0;
      gl   = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < DIV1; c++) begin
            if (b != 0 || c != 0) begin
               @(posedge clock); #1;
            end
            if (c == 0) bits[b] = txd1;
            else if (txd1 !== bits[b]) gl++;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while (busy1 && n < limit) begin
         @(posedge clock); #1;
         n++;
      end
      chk(name, {31'd0, busy1}, 32'd0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   initial begin : main
      vec_t         vecs [4];
      logic [99:0]  bits;
      int           gl;
      int           bad;
      logic [7:0]   b3 [6];
      byte unsigned mq[$];
      byte unsigned acc[$];
      int           rem;
      logic         movf;
      logic         v;
      logic         c;
      logic [7:0]   d;
      logic         mfull;

      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h3C, 10'b1001111000};
      b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33;
      b3[3] = 8'h44; b3[4] = 8'h55; b3[5] = 8'h66;

      data1 = 8'h00; valid1 = 1'b0; clr1 = 1'b0;
      data2 = 8'h00; valid2 = 1'b0; clr2 = 1'b0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #2;
      chk("rst_txd", {31'd0, txd1}, 32'd1);
      chk("rst_level", {29'd0, level1}, 32'd0);
      chk("rst_ready", {31'd0, ready1}, 32'd1);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_ovf", {31'd0, ovf1}, 32'd0);
      chk("rst_txd2", {31'd0, txd2}, 32'd1);
      chk("rst_level2", {30'd0, level2}, 32'd0);
      repeat (3) @(posedge clock);
      #3 resetn = 1'b1;
      @(posedge clock); #1;

      // Single frames from the vector table.
      foreach (vecs[i]) begin
         push1(vecs[i].data);
         chk("t1_level_after_push", {29'd0, level1}, 32'd1);
         chk("t1_txd_before_pop", {31'd0, txd1}, 32'd1);
         @(posedge clock); #1;
         sample_line(10, bits, gl);
         chk("t1_frame", {22'd0, bits[9:0]}, {22'd0, vecs[i].frame});
         chk("t1_glitch", gl, 0);
         chk("t1_busy_stop", {31'd0, busy1}, 32'd1);
         @(posedge clock); #1;
         chk("t1_busy_end", {31'd0, busy1}, 32'd0);
         chk("t1_txd_idle", {31'd0, txd1}, 32'd1);
      end

      // Back-to-back frames with no idle gap.
      data1 = 8'h55; valid1 = 1'b1;
      @(posedge clock); #1;
      data1 = 8'h0F;
      @(posedge clock); #1;
      valid1 = 1'b0;
      sample_line(20, bits, gl);
      chk("t2_frames", {12'd0, bits[19:0]},
          {12'd0, frame_of(8'h0F), frame_of(8'h55)});
      chk("t2_glitch", gl, 0);
      chk("t2_busy_last", {31'd0, busy1}, 32'd1);
      @(posedge clock); #1;
      chk("t2_busy_end", {31'd0, busy1}, 32'd0);

      // Overflow while the line is busy.
      rxq0.delete();
      for (int i = 0; i < 6; i++) begin
         data1  = b3[i];
         valid1 = 1'b1;
         @(posedge clock); #1;
         if (i == 3) begin
            chk("t3_ready_3", {31'd0, ready1}, 32'd1);
            chk("t3_level_3", {29'd0, level1}, 32'd3);
         end
         if (i == 4) begin
            chk("t3_ready_full", {31'd0, ready1}, 32'd0);
            chk("t3_level_full", {29'd0, level1}, 32'd4);
            chk("t3_ovf_pre", {31'd0, ovf1}, 32'd0);
         end
         if (i == 5) begin
            chk("t3_ovf", {31'd0, ovf1}, 32'd1);
            chk("t3_level_drop", {29'd0, level1}, 32'd4);
         end
      end
      valid1 = 1'b0;
      wait_idle("t3_drain", 400);
      chk("t3_rx_count", rxq0.size(), 5);
      for (int i = 0; i < 5 && i < rxq0.size(); i++)
         chk("t3_rx_byte", {24'd0, rxq0[i]}, {24'd0, b3[i]});
      chk("t3_ovf_sticky", {31'd0, ovf1}, 32'd1);

      // Clear alone, then clear coincident with an overflowing push.
      clr1 = 1'b1;
      @(posedge clock); #1;
      clr1 = 1'b0;
      chk("t4_clear", {31'd0, ovf1}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         data1  = b3[i];
         valid1 = 1'b1;
         @(posedge clock); #1;
      end
      data1 = 8'h99;
      clr1  = 1'b1;
      @(posedge clock); #1;
      valid1 = 1'b0;
      chk("t4_set_wins", {31'd0, ovf1}, 32'd1);
      @(posedge clock); #1;
      clr1 = 1'b0;
      chk("t4_clear_after", {31'd0, ovf1}, 32'd0);
      wait_idle("t4_drain", 400);

      // Asynchronous reset in the middle of a data bit.
      rxq0.delete();
      clr1 = 1'b1;
      push1(8'h00);
      clr1 = 1'b0;
      push1(8'h77);
      repeat (10) @(posedge clock);
      #4;
      chk("t5_txd_before", {31'd0, txd1}, 32'd0);
      resetn = 1'b0;
      #1;
      chk("t5_txd_async", {31'd0, txd1}, 32'd1);
      chk("t5_level", {29'd0, level1}, 32'd0);
      chk("t5_busy", {31'd0, busy1}, 32'd0);
      chk("t5_ready", {31'd0, ready1}, 32'd1);
      #2 resetn = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock); #1;
         if (txd1 !== 1'b1 || busy1 !== 1'b0) bad++;
      end
      chk("t5_no_residual", bad, 0);
      chk("t5_rx_empty", rxq0.size(), 0);

      // Randomized traffic on the small instance.
      rxq1.delete();
      rem  = 0;
      movf = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         chk("t6_status", {27'd0, busy2, ready2, ovf2, level2},
             {27'd0, (rem > 0 || mq.size() > 0),
              (mq.size() < DEP2), movf, 2'(mq.size())});
         v = (cyc < 700) && ($urandom_range(0, 9) == 0);
         c = ($urandom_range(0, 15) == 0);
         d = 8'($urandom);
         data2  = d;
         valid2 = v;
         clr2   = c;
         @(posedge clock);
         mfull = (mq.size() == DEP2);
         if (rem > 0) rem--;
         if (rem == 0 && mq.size() > 0) begin
            void'(mq.pop_front());
            rem = 10 * DIV2;
         end
         if (v && mfull) begin
            movf = 1'b1;
         end else begin
            if (v) begin
               mq.push_back(d);
               acc.push_back(d);
            end
            if (c) movf = 1'b0;
         end
         #1;
      end
      valid2 = 1'b0;
      clr2   = 1'b0;
      chk("t6_rx_count", rxq1.size(), acc.size());
      for (int i = 0; i < acc.size() && i < rxq1.size(); i++)
         chk("t6_rx_byte", {24'd0, rxq1[i]}, {24'd0, acc[i]});
      chk("mon_framing", mon_ferr, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
